// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Purpose  : Shared constants and types for the registered 1-to-2 demux:
//             default data width, channel identifiers and slot states.
//  Contents : DEMUX_WIDTH_DEFAULT  default width of In/OutA/OutB
//             channel_e            CH_A=0, CH_B=1
//             slot_state_e         EMPTY, FULL
//             slot_can_load()      whether a slot can take a word this cycle
//  Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

  localparam int DEMUX_WIDTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // A slot can be loaded when it is empty, or when its current word leaves
  // in the same cycle (pass-through refill without a bubble).
  function automatic logic slot_can_load(input slot_state_e st, input logic take);
    return (st == EMPTY) || take;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry output buffer for a single demux channel. Holds a word
//             from load until the consumer takes it.
//  Ports    : clk         rising-edge clock
//             reset       asynchronous active-high reset (slot EMPTY, data 0)
//             load_i      write data_i into the slot this cycle
//             data_i      word to store
//             take_i      consumer takes the stored word (ignored when EMPTY)
//             can_load_o  slot is able to accept a load this cycle
//             valid_o     slot is FULL
//             data_o      stored word (held after draining)
//  Revision : 1.0  initial release
// ============================================================================
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             take_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             take_eff;

  // A take against an empty slot has no meaning and must not disturb it.
  assign take_eff = take_i && (state_q == FULL);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load_i)              state_d = FULL;
      FULL:    if (take_eff && !load_i) state_d = EMPTY;
      default:                          state_d = EMPTY;
    endcase
  end

  // Data register keeps its last word after draining.
  assign data_d = load_i ? data_i : data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Output logic
  always_comb begin
    valid_o    = (state_q == FULL);
    can_load_o = slot_can_load(state_q, take_eff);
    data_o     = data_q;
  end

endmodule
`default_nettype wire

// File: rtl/demux2_4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux2_4_reg
//  Purpose  : Registered 1-to-2 demultiplexer with valid/ready handshakes.
//             Each accepted word lands in the one-entry slot of channel A or B
//             and appears there one cycle later. A full channel only stalls
//             words that are routed to it.
//  Ports    : clk, reset          clock, asynchronous active-high reset
//             In, in_valid        input word and its valid
//             in_ready            word can be accepted this cycle
//             s                   destination select (0=A, 1=B)
//             alt                 (DEMUX_ALT_EN only) 1: alternate A,B,A,...
//             OutA, a_valid, a_ready   channel A data/valid/ready
//             OutB, b_valid, b_ready   channel B data/valid/ready
//  Config   : DEMUX_ALT_EN  adds the alt port and the alternate pointer.
//  Revision : 1.0  initial release
// ============================================================================
module demux2_4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] In,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
`ifdef DEMUX_ALT_EN
  input  logic             alt,
`endif
  output logic [WIDTH-1:0] OutA,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] OutB,
  output logic             b_valid,
  input  logic             b_ready
);

  channel_e sel;
  logic     a_can_load;
  logic     b_can_load;
  logic     accept;
  logic     load_a;
  logic     load_b;

`ifdef DEMUX_ALT_EN
  channel_e ptr_q, ptr_d;

  always_comb begin
    sel = alt ? ptr_q : channel_e'(s);
  end

  // Pointer moves only when a word is actually taken in alternate mode.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && alt) begin
      ptr_d = (ptr_q == CH_A) ? CH_B : CH_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= CH_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    sel = channel_e'(s);
  end
`endif

  // in_ready is gated by reset so nothing is accepted while it is held.
  always_comb begin
    in_ready = !reset && ((sel == CH_A) ? a_can_load : b_can_load);
    accept   = in_valid && in_ready;
    load_a   = accept && (sel == CH_A);
    load_b   = accept && (sel == CH_B);
  end

  demux_slot #(
    .WIDTH (WIDTH)
  ) u_slot_a (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_a),
    .data_i     (In),
    .take_i     (a_ready),
    .can_load_o (a_can_load),
    .valid_o    (a_valid),
    .data_o     (OutA)
  );

  demux_slot #(
    .WIDTH (WIDTH)
  ) u_slot_b (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_b),
    .data_i     (In),
    .take_i     (b_ready),
    .can_load_o (b_can_load),
    .valid_o    (b_valid),
    .data_o     (OutB)
  );

endmodule
`default_nettype wire

// File: tb/tb_demux2_4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux2_4_reg
//  Purpose  : Self-checking bench for demux2_4_reg: directed vectors followed
//             by a back-pressure stream checked against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux2_4_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] In;
  logic       in_valid;
  logic       in_ready;
  logic       s;
`ifdef DEMUX_ALT_EN
  logic       alt;
`endif
  logic [3:0] OutA;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] OutB;
  logic       b_valid;
  logic       b_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux2_4_reg #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .In       (In),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
`ifdef DEMUX_ALT_EN
    .alt      (alt),
`endif
    .OutA     (OutA),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .OutB     (OutB),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0] qa[$];
  logic [3:0] qb[$];

  initial begin
    logic exp_rdy;
    logic take_a, take_b, acc;
    logic [3:0] word;
    int accepted;
    int cyc;

    reset = 1'b0; In = 4'h0; in_valid = 1'b0; s = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
`ifdef DEMUX_ALT_EN
    alt = 1'b0;
`endif
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_a_valid", a_valid, 1'b0);
    chk1("rst_b_valid", b_valid, 1'b0);
    chk4("rst_OutA", OutA, 4'h0);
    chk4("rst_OutB", OutB, 4'h0);
    // No accept while reset is held, even with empty slots.
    In = 4'hF; in_valid = 1'b1;
    #1 chk1("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rst_no_accept", a_valid, 1'b0);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // Single word to A
    In = 4'hA; s = 1'b0; in_valid = 1'b1;
    #1 chk1("a1_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("a1_a_valid", a_valid, 1'b1);
    chk4("a1_OutA", OutA, 4'hA);
    chk1("a1_b_valid", b_valid, 1'b0);

    // A full and stalled: A blocked, B still flows
    In = 4'h3; s = 1'b0; in_valid = 1'b1; a_ready = 1'b0;
    #1 chk1("stall_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk1("stall_a_valid", a_valid, 1'b1);
    chk4("stall_OutA", OutA, 4'hA);
    In = 4'h5; s = 1'b1;
    #1 chk1("b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("b_b_valid", b_valid, 1'b1);
    chk4("b_OutB", OutB, 4'h5);
    chk4("b_OutA_hold", OutA, 4'hA);

    // Drain both, then keep ready high while empty
    a_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    chk1("drain_a_valid", a_valid, 1'b0);
    chk1("drain_b_valid", b_valid, 1'b0);
    chk4("drain_OutA_keep", OutA, 4'hA);
    @(posedge clk); #1;
    chk1("empty_ready_a", a_valid, 1'b0);
    chk4("empty_ready_OutB", OutB, 4'h5);

    // Simultaneous take and refill on A
    a_ready = 1'b0; b_ready = 1'b0;
    In = 4'h1; s = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk4("refill_pre_OutA", OutA, 4'h1);
    a_ready = 1'b1; In = 4'h2;
    #1 chk1("refill_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; a_ready = 1'b0;
    chk1("refill_a_valid", a_valid, 1'b1);
    chk4("refill_OutA", OutA, 4'h2);

    // Fill B, then async reset mid-cycle with both full
    In = 4'h7; s = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("both_full_b", b_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("arst_a_valid", a_valid, 1'b0);
    chk1("arst_b_valid", b_valid, 1'b0);
    chk4("arst_OutA", OutA, 4'h0);
    chk4("arst_OutB", OutB, 4'h0);
    In = 4'h9; s = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk1("arst_no_accept", a_valid, 1'b0);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

`ifdef DEMUX_ALT_EN
    // Alternate routing, s driven opposite to the expected destination
    alt = 1'b1; a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      In = 4'(i);
      s  = (i % 2 == 1);
      #1 chk1("alt_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      if (i % 2 == 1) begin
        chk1("alt_a_valid", a_valid, 1'b1);
        chk4("alt_OutA", OutA, 4'(i));
        chk1("alt_b_idle", b_valid, 1'b0);
      end else begin
        chk1("alt_b_valid", b_valid, 1'b1);
        chk4("alt_OutB", OutB, 4'(i));
        chk1("alt_a_idle", a_valid, 1'b0);
      end
    end
    in_valid = 1'b0; alt = 1'b0;
    @(posedge clk); #1;
`endif

    // Random back-pressure stream against a queue model
    a_ready = 1'b0; b_ready = 1'b0;
    @(posedge clk); #1;
    qa.delete(); qb.delete();
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      cyc++;
      in_valid = 1'($urandom_range(0, 1));
      In       = 4'($urandom_range(0, 15));
      s        = 1'($urandom_range(0, 1));
      a_ready  = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      #3;
      chk1("rnd_a_valid", a_valid, qa.size() != 0);
      chk1("rnd_b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) chk4("rnd_OutA", OutA, qa[0]);
      if (qb.size() != 0) chk4("rnd_OutB", OutB, qb[0]);
      exp_rdy = s ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
      chk1("rnd_in_ready", in_ready, exp_rdy);
      take_a = (qa.size() != 0) && a_ready;
      take_b = (qb.size() != 0) && b_ready;
      acc    = in_valid && exp_rdy;
      word   = In;
      @(posedge clk); #1;
      if (take_a) void'(qa.pop_front());
      if (take_b) void'(qb.pop_front());
      if (acc) begin
        if (s) qb.push_back(word);
        else   qa.push_back(word);
        accepted++;
      end
    end
    chk1("rnd_all_accepted", accepted == 1000, 1'b1);

    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("final_a_empty", a_valid, 1'b0);
    chk1("final_b_empty", b_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux2_4_reg.md
DEMUX2_4_REG -- requirements
Module: demux2_4_reg

Interface
REQ-001 Parameter: WIDTH, default 4, data width of the input word and of each output channel.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: In  input  WIDTH  input data word.
REQ-005 Port: in_valid  input  1  In carries a word to route.
REQ-006 Port: in_ready  output  1  block accepts In this cycle.
REQ-007 Port: s  input  1  destination select, sampled with the word (0 selects A, 1 selects B).
REQ-008 Port: OutA  output  WIDTH  channel A data.
REQ-009 Port: a_valid  output  1  OutA holds an unconsumed word.
REQ-010 Port: a_ready  input  1  channel A consumer takes OutA.
REQ-011 Port: OutB, b_valid, b_ready  same as OutA, a_valid, a_ready, for channel B.
REQ-012 Fixed design decision: one clock, clk; reset is asynchronous and active-high, named reset.

Function
REQ-013 Each channel SHALL own a one-entry slot with states EMPTY and FULL; x_valid=1 exactly when the slot is FULL.
REQ-014 Accept occurs when in_valid&&in_ready at a clk edge; the word SHALL go to the slot chosen by s in that cycle.
REQ-015 in_ready SHALL be 1 when the selected slot is EMPTY, or when it is FULL and its x_ready=1 in the same cycle.
REQ-016 Latency SHALL be one cycle: a word accepted at edge N appears on OutX with x_valid=1 after edge N.
REQ-017 Transitions: EMPTY->FULL on accept; FULL->EMPTY on x_ready with no accept; FULL->FULL with new data on simultaneous x_ready and accept.
REQ-018 While x_valid=1 and x_ready=0, OutX SHALL hold stable.
REQ-019 The non-selected slot SHALL be unaffected by an accept; a full A SHALL NOT stall traffic selected to B, and vice versa.
REQ-020 x_ready while EMPTY SHALL be ignored.
REQ-021 OutX SHALL retain its last data after the slot drains; it is don't-care while x_valid=0.
REQ-022 No combinational path SHALL exist from In, in_valid or s to any Out or x_valid; in_ready MAY depend combinationally on s and x_ready.

Reset
REQ-023 On reset assertion, regardless of clk, both slots SHALL go EMPTY: a_valid=b_valid=0, OutA=OutB=0, and the alternate pointer SHALL be A.
REQ-024 A word in flight when reset is asserted SHALL be discarded; no word SHALL be accepted while reset=1.

Configuration
REQ-025 Macro DEMUX_ALT_EN: when defined, an input port alt (1 bit) SHALL exist; with alt=1, s is ignored and the destination SHALL alternate A,B,A,... per accepted word, pointer advancing only on accept; with alt=0, s routes.
REQ-026 Without DEMUX_ALT_EN, the alt port and the pointer SHALL be absent and routing SHALL use s only.

Structure
REQ-027 Package demux_pkg SHALL hold the WIDTH default constant, the channel enum (CH_A=0, CH_B=1) and the slot state enum (EMPTY, FULL).
REQ-028 Sub-module demux_slot (the one-entry buffer with load/take/valid) SHALL be instantiated twice, once per channel.

Verification
REQ-029 Reset, then In=4'hA, s=0, in_valid=1 for one cycle -> next cycle a_valid=1, OutA=4'hA, b_valid=0.
REQ-030 A FULL with a_ready=0, send In=4'h3 with s=0 -> in_ready=0 and OutA unchanged; then send In=4'h5 with s=1 -> accepted, OutB=4'h5.
REQ-031 A FULL (4'h1), a_ready=1 and In=4'h2 with s=0 in the same cycle -> accepted, next cycle OutA=4'h2 and a_valid=1.
REQ-032 Assert reset asynchronously mid-cycle with both slots FULL -> a_valid=b_valid=0 immediately, OutA=OutB=0.
REQ-033 DEMUX_ALT_EN defined, alt=1, stream 4'h1..4'h4 with both readies=1 -> A receives 1,3 and B receives 2,4, regardless of s.
REQ-034 Random valid/ready back-pressure, 1000 words -> per-channel output order equals input order, with no loss and no duplication.
